iob_native_mem_responder: RTL and testbench

//  Responder (target) end of the native back-end memory interface driven by iob_cache (mem_valid/addr/wdata/wstrb -> mem_rdata/ready).

---
 rtl/iob_native_mem_responder_pkg.sv | 12 +
 rtl/iob_sp_ram.sv | 31 +++
 rtl/iob_native_mem_responder.sv | 117 +++++++++++
 tb/tb_iob_native_mem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/iob_native_mem_responder_pkg.sv
// rtl/iob_native_mem_responder_pkg.sv - shared types and constants for the native memory responder
package iob_native_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LAT_CNT_W = 8;

endpackage

// File: rtl/iob_sp_ram.sv
// rtl/iob_sp_ram.sv - single-port byte-enabled RAM with registered read
module iob_sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [(1<<ADDR_W)];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // An enabled access with no byte enables is a read; the output register holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else if (en && be == '0) rdata <= mem[addr];
  end

endmodule

// File: rtl/iob_native_mem_responder.sv
// rtl/iob_native_mem_responder.sv - native memory interface responder with latency and stall injection
module iob_native_mem_responder
  import iob_native_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH_W = 10,
  parameter int RD_LAT      = 1,
  parameter int WR_LAT      = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  input  logic                  stall,
  output logic                  busy,
  output logic [CNT_W-1:0]      n_reads,
  output logic [CNT_W-1:0]      n_writes
);

  localparam int N_BYTES  = DATA_W / 8;
  localparam int OFFSET_W = $clog2(N_BYTES);
  localparam logic [LAT_CNT_W-1:0] RD_LOAD = LAT_CNT_W'(RD_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] WR_LOAD = LAT_CNT_W'(WR_LAT - 1);

  state_t                  state;
  logic [LAT_CNT_W-1:0]    cnt;
  logic [MEM_DEPTH_W-1:0]  idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [N_BYTES-1:0]      wstrb_q;

  logic [MEM_DEPTH_W-1:0]  bus_idx;
  logic [LAT_CNT_W-1:0]    load_cnt;
  logic                    accept;
  logic                    commit;
  logic [MEM_DEPTH_W-1:0]  ram_idx;
  logic [DATA_W-1:0]       ram_wdata;
  logic [N_BYTES-1:0]      ram_strb;
  logic                    unused_addr;

  assign bus_idx     = mem_addr[OFFSET_W +: MEM_DEPTH_W];
  assign unused_addr = ^mem_addr;
  assign load_cnt    = (|mem_wstrb) ? WR_LOAD : RD_LOAD;
  assign busy        = (state != ST_IDLE);

  // In WAIT, cnt counts the remaining edges including the commit edge itself.
  always_comb begin
    accept    = reset && (state == ST_IDLE) && mem_valid && !stall;
    commit    = (accept && load_cnt == '0) ||
                ((state == ST_WAIT) && !stall && cnt == LAT_CNT_W'(1));
    ram_idx   = idx_q;
    ram_wdata = wdata_q;
    ram_strb  = wstrb_q;
    if (state == ST_IDLE) begin
      ram_idx   = bus_idx;
      ram_wdata = mem_wdata;
      ram_strb  = mem_wstrb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_ready <= 1'b0;
      n_reads   <= '0;
      n_writes  <= '0;
    end else begin
      mem_ready <= commit;
      if (commit) begin
        if (|ram_strb) n_writes <= n_writes + 1'b1;
        else           n_reads  <= n_reads + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= bus_idx;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            cnt     <= load_cnt;
            state   <= (load_cnt == '0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!stall) begin
            if (commit) state <= ST_RESP;
            else        cnt   <= cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  iob_sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_DEPTH_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (commit),
    .be    (commit ? ram_strb : '0),
    .addr  (ram_idx),
    .wdata (ram_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_iob_native_mem_responder.sv
// tb/tb_iob_native_mem_responder.sv - directed self-checking bench for iob_native_mem_responder
module tb_iob_native_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        stall [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        busy  [2];
  logic [7:0]  nr0, nw0;
  logic [15:0] nr1, nw1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iob_native_mem_responder #(.CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]),
    .mem_ready(ready[0]), .stall(stall[0]), .busy(busy[0]),
    .n_reads(nr0), .n_writes(nw0)
  );

  iob_native_mem_responder #(.RD_LAT(4), .WR_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]),
    .mem_ready(ready[1]), .stall(stall[1]), .busy(busy[1]),
    .n_reads(nr1), .n_writes(nw1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid is held through the RESP edge to confirm it is not re-accepted.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] s, output int edges, output logic [31:0] rd);
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = w;
    wstrb[d] = s;
    edges = 0;
    rd = 'x;
    for (int k = 0; k < 20; k++) begin
      tick();
      edges++;
      if (ready[d]) break;
    end
    rd = rdata[d];
    tick();
    check("one_pulse", {31'd0, ready[d]}, 32'd0);
    valid[d] = 1'b0;
    wstrb[d] = 4'h0;
  endtask

  int lat;
  logic [31:0] rd;

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0; stall[d] = 1'b0;
    end
    repeat (2) tick();
    check("rst_ready", {31'd0, ready[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check("rst_nr", {24'd0, nr0}, 32'd0);
    check("rst_nw", {24'd0, nw0}, 32'd0);
    reset = 1'b1;
    tick();

    txn(0, 32'h48D0, 32'hDEADBEEF, 4'hF, lat, rd);
    check("wr_lat1", lat, 1);
    check("wr_nw", {24'd0, nw0}, 32'd1);
    check("wr_nr", {24'd0, nr0}, 32'd0);

    txn(0, 32'h48D0, 32'h0, 4'h0, lat, rd);
    check("rd_lat1", lat, 1);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_nr", {24'd0, nr0}, 32'd1);
    check("rd_nw", {24'd0, nw0}, 32'd1);

    txn(0, 32'h48D0, 32'h000000AA, 4'h1, lat, rd);
    check("rdata_hold", rdata[0], 32'hDEADBEEF);
    txn(0, 32'h48D0, 32'h0, 4'h0, lat, rd);
    check("strb1", rd, 32'hDEADBEAA);

    txn(0, 32'h48D0, 32'h11223344, 4'h6, lat, rd);
    txn(0, 32'h48D0, 32'h0, 4'h0, lat, rd);
    check("strb6", rd, 32'hDE2233AA);

    txn(0, 32'h0014, 32'h5A5A5A5A, 4'hF, lat, rd);
    txn(0, 32'h1014, 32'h0, 4'h0, lat, rd);
    check("alias", rd, 32'h5A5A5A5A);

    stall[0] = 1'b1;
    valid[0] = 1'b1;
    addr[0]  = 32'h48D0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_stall_busy", {31'd0, busy[0]}, 32'd0);
      check("idle_stall_ready", {31'd0, ready[0]}, 32'd0);
    end
    valid[0] = 1'b0;
    stall[0] = 1'b0;
    tick();
    check("cnt_nr", {24'd0, nr0}, 32'd4);
    check("cnt_nw", {24'd0, nw0}, 32'd4);

    for (int i = 0; i < 251; i++) txn(0, 32'h0100, i, 4'hF, lat, rd);
    check("nw_max", {24'd0, nw0}, 32'h000000FF);
    txn(0, 32'h0100, 32'h0, 4'hF, lat, rd);
    check("nw_wrap", {24'd0, nw0}, 32'd0);
    check("nr_keep", {24'd0, nr0}, 32'd4);

    txn(1, 32'h0010, 32'hCAFEF00D, 4'hF, lat, rd);
    check("wr_lat3", lat, 3);
    check("wr_nw1", {16'd0, nw1}, 32'd1);

    valid[1] = 1'b1;
    addr[1]  = 32'h0010;
    wstrb[1] = 4'h0;
    tick();
    check("acc_busy", {31'd0, busy[1]}, 32'd1);
    stall[1] = 1'b1;
    repeat (3) tick();
    check("stall_ready", {31'd0, ready[1]}, 32'd0);
    check("stall_busy", {31'd0, busy[1]}, 32'd1);
    stall[1] = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (ready[1]) break;
    end
    check("stall_lat", lat, 3);
    check("stall_rdata", rdata[1], 32'hCAFEF00D);
    check("stall_nr1", {16'd0, nr1}, 32'd1);
    tick();
    valid[1] = 1'b0;

    valid[1] = 1'b1;
    addr[1]  = 32'h0010;
    wdata[1] = 32'h12345678;
    wstrb[1] = 4'hF;
    tick();
    check("rst_wait_busy", {31'd0, busy[1]}, 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready[1]}, 32'd0);
    check("abort_rdata", rdata[1], 32'd0);
    check("abort_nr1", {16'd0, nr1}, 32'd0);
    check("abort_nw1", {16'd0, nw1}, 32'd0);
    check("abort_busy", {31'd0, busy[1]}, 32'd0);
    check("abort_nw0", {24'd0, nw0}, 32'd0);
    valid[1] = 1'b0;
    wstrb[1] = 4'h0;
    tick();
    reset = 1'b1;
    tick();
    txn(1, 32'h0010, 32'h0, 4'h0, lat, rd);
    check("rd_lat4", lat, 4);
    check("abort_nowrite", rd, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
